// File: rtl/tail_light_scheduler_pkg.sv
// Shared types and defaults for the tail-light scheduler.
// TAIL_LIGHT_HAZARD_EN adds a fourth (hazard) switch channel.
package tail_light_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RUN_L   = 3'd1,
    RUN_R   = 3'd2,
    FAULT   = 3'd3,
    RECOVER = 3'd4
  } state_e;

  localparam int STEP_DIV_DEF   = 4;
  localparam int DEBOUNCE_DEF   = 2;
  localparam int MIN_HOLD_DEF   = 3;
  localparam int FAULT_HOLD_DEF = 4;

  localparam int SW_LEFT   = 0;
  localparam int SW_RIGHT  = 1;
  localparam int SW_BRAKE  = 2;
  localparam int SW_HAZARD = 3;

`ifdef TAIL_LIGHT_HAZARD_EN
  localparam int NUM_SW = 4;
`else
  localparam int NUM_SW = 3;
`endif

  // Width of a counter that runs 0..n-1.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tail_light_scheduler_if.sv
// Switch inputs and lamp-command outputs of the scheduler.
// TAIL_LIGHT_HAZARD_EN adds sw_hazard.
interface tail_light_scheduler_if;
  logic sw_left, sw_right, sw_brake, lamp_error;
`ifdef TAIL_LIGHT_HAZARD_EN
  logic sw_hazard;
`endif
  logic step, cmd_left, cmd_right, cmd_brake, cmd_restart, fault, busy;

`ifdef TAIL_LIGHT_HAZARD_EN
  modport master (output sw_left, sw_right, sw_brake, sw_hazard, lamp_error,
                  input  step, cmd_left, cmd_right, cmd_brake, cmd_restart, fault, busy);
  modport slave  (input  sw_left, sw_right, sw_brake, sw_hazard, lamp_error,
                  output step, cmd_left, cmd_right, cmd_brake, cmd_restart, fault, busy);
`else
  modport master (output sw_left, sw_right, sw_brake, lamp_error,
                  input  step, cmd_left, cmd_right, cmd_brake, cmd_restart, fault, busy);
  modport slave  (input  sw_left, sw_right, sw_brake, lamp_error,
                  output step, cmd_left, cmd_right, cmd_brake, cmd_restart, fault, busy);
`endif
endinterface

// File: rtl/tail_light_scheduler_switch_debounce.sv
// Two-flop synchroniser plus run-length filter for one raw switch.
module switch_debounce
  import tail_light_pkg::*;
#(
  parameter int DEBOUNCE = DEBOUNCE_DEF
) (
  input  logic clka,
  input  logic restart,
  input  logic raw,
  output logic filt
);
  localparam int CW = cnt_w(DEBOUNCE);

  logic [1:0]    sync;
  logic [CW-1:0] cnt;

  // Any clock where the synchronised value agrees with filt restarts the run.
  always_ff @(posedge clka) begin
    if (restart) begin
      sync <= '0;
      cnt  <= '0;
      filt <= 1'b0;
    end else begin
      sync <= {sync[0], raw};
      if (sync[1] == filt) begin
        cnt <= '0;
      end else if (cnt == CW'(DEBOUNCE - 1)) begin
        filt <= sync[1];
        cnt  <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end
endmodule

// File: rtl/tail_light_scheduler.sv
// Tail-light sequencing front-end: switch filtering, step generation, turn arbitration.
// TAIL_LIGHT_HAZARD_EN enables the hazard switch and left/right alternation.
module tail_light_scheduler
  import tail_light_pkg::*;
#(
  parameter int STEP_DIV   = STEP_DIV_DEF,
  parameter int DEBOUNCE   = DEBOUNCE_DEF,
  parameter int MIN_HOLD   = MIN_HOLD_DEF,
  parameter int FAULT_HOLD = FAULT_HOLD_DEF
) (
  input  logic                   clka,
  input  logic                   restart,
  tail_light_scheduler_if.slave  bus
);
  localparam int SW = cnt_w(STEP_DIV);
  localparam int HW = cnt_w(MIN_HOLD);
  localparam int FW = cnt_w(FAULT_HOLD);

  logic [NUM_SW-1:0] raw_sw, f_sw;
  logic [SW-1:0]     step_cnt;
  logic [HW-1:0]     hold_cnt, hold_nx;
  logic [FW-1:0]     fault_cnt, fault_nx;
  state_e            state, state_nx, arb;
  logic              step, f_left, f_right, f_brake, conflict;

  assign raw_sw[SW_LEFT]  = bus.sw_left;
  assign raw_sw[SW_RIGHT] = bus.sw_right;
  assign raw_sw[SW_BRAKE] = bus.sw_brake;
`ifdef TAIL_LIGHT_HAZARD_EN
  assign raw_sw[SW_HAZARD] = bus.sw_hazard;
`endif

  for (genvar i = 0; i < NUM_SW; i++) begin : g_sw
    switch_debounce #(.DEBOUNCE(DEBOUNCE)) u_db (
      .clka    (clka),
      .restart (restart),
      .raw     (raw_sw[i]),
      .filt    (f_sw[i])
    );
  end

  assign f_left   = f_sw[SW_LEFT];
  assign f_right  = f_sw[SW_RIGHT];
  assign f_brake  = f_sw[SW_BRAKE];
  assign conflict = f_left & f_right;
  assign step     = (step_cnt == SW'(STEP_DIV - 1));

  always_ff @(posedge clka) begin
    if (restart) begin
      state     <= IDLE;
      step_cnt  <= '0;
      hold_cnt  <= '0;
      fault_cnt <= '0;
    end else begin
      state     <= state_nx;
      step_cnt  <= step ? '0 : step_cnt + SW'(1);
      hold_cnt  <= hold_nx;
      fault_cnt <= fault_nx;
    end
  end

  // Target when deciding from scratch (IDLE or at a hold boundary).
  always_comb begin
    arb = IDLE;
`ifdef TAIL_LIGHT_HAZARD_EN
    if (f_sw[SW_HAZARD])  arb = (state == RUN_L) ? RUN_R : RUN_L;
    else if (f_left)      arb = RUN_L;
    else if (f_right)     arb = RUN_R;
`else
    if (f_left)           arb = RUN_L;
    else if (f_right)     arb = RUN_R;
`endif
  end

  always_comb begin
    state_nx = state;
    hold_nx  = hold_cnt;
    fault_nx = fault_cnt;
    if (step) begin
      case (state)
        IDLE, RUN_L, RUN_R: begin
          if (bus.lamp_error || conflict) begin
            state_nx = FAULT;
            hold_nx  = '0;
          end else if (state != IDLE && hold_cnt < HW'(MIN_HOLD - 1)) begin
            hold_nx = hold_cnt + HW'(1);
          end else begin
            state_nx = arb;
            hold_nx  = '0;
          end
        end
        FAULT: begin
          if (fault_cnt < FW'(FAULT_HOLD - 1)) begin
            fault_nx = fault_cnt + FW'(1);
          end else if (!conflict) begin
            state_nx = RECOVER;
            fault_nx = '0;
          end
        end
        RECOVER: state_nx = IDLE;
        default: state_nx = IDLE;
      endcase
    end
  end

  always_comb begin
    bus.step        = step;
    bus.cmd_left    = (state == RUN_L);
    bus.cmd_right   = (state == RUN_R);
    bus.busy        = (state == RUN_L) || (state == RUN_R);
    bus.cmd_brake   = f_brake && (state == IDLE || state == RUN_L || state == RUN_R);
    bus.fault       = (state == FAULT);
    bus.cmd_restart = restart || (state == RECOVER);
  end
endmodule

// File: tb/tb_tail_light_scheduler.sv
// Scenario bench for tail_light_scheduler at default parameters (hazard build not exercised).
module tb_tail_light_scheduler;

  typedef struct {
    string      nm;
    logic [6:0] v;   // {step, left, right, brake, restart, fault, busy}
  } exp_t;

  logic clka = 1'b0;
  logic restart;
  int   n_chk  = 0;
  int   n_pass = 0;
  exp_t sb[$];

  tail_light_scheduler_if bus();
  tail_light_scheduler dut (.clka(clka), .restart(restart), .bus(bus));

  always #5 clka = ~clka;

  function automatic logic [6:0] pk(bit st, bit l, bit r, bit b, bit rs, bit f, bit bz);
    return {st, l, r, b, rs, f, bz};
  endfunction

  // Queue the expectation for the next edge, then pop it against the DUT.
  task automatic cyc(input string nm, input logic [6:0] v);
    exp_t e, got;
    logic [6:0] act;
    e.nm = nm;
    e.v  = v;
    sb.push_back(e);
    @(posedge clka);
    #1;
    got = sb.pop_front();
    act = {bus.step, bus.cmd_left, bus.cmd_right, bus.cmd_brake,
           bus.cmd_restart, bus.fault, bus.busy};
    n_chk++;
    if (act !== got.v)
      $display("FAIL %s t=%0t: got %b expected %b", got.nm, $time, act, got.v);
    else
      n_pass++;
  endtask

  task automatic clear_inputs();
    bus.sw_left = 1'b0; bus.sw_right = 1'b0; bus.sw_brake = 1'b0; bus.lamp_error = 1'b0;
`ifdef TAIL_LIGHT_HAZARD_EN
    bus.sw_hazard = 1'b0;
`endif
  endtask

  // Leaves the bench just after the last reset edge (edge index 0).
  task automatic do_reset();
    clear_inputs();
    restart = 1'b1;
    repeat (2) @(posedge clka);
    #1;
    restart = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    restart = 1'b1;
    cyc("reset0", pk(0, 0, 0, 0, 1, 0, 0));
    cyc("reset1", pk(0, 0, 0, 0, 1, 0, 0));
    restart = 1'b0;
    for (int k = 1; k <= 20; k++)
      cyc("idle_step", pk(k % 4 == 3, 0, 0, 0, 0, 0, 0));
  endtask

  task automatic test_left_hold();
    do_reset();
    bus.sw_left = 1'b1;
    for (int k = 1; k <= 22; k++)
      cyc("left_hold", pk(k % 4 == 3, k >= 8, 0, 0, 0, 0, k >= 8));
  endtask

  task automatic test_glitch();
    do_reset();
    bus.sw_left = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      cyc("glitch", pk(k % 4 == 3, 0, 0, 0, 0, 0, 0));
      bus.sw_left = 1'b0;
    end
  endtask

  task automatic test_min_hold();
    do_reset();
    bus.sw_left = 1'b1;
    for (int k = 1; k <= 24; k++) begin
      cyc("min_hold", pk(k % 4 == 3, k >= 8 && k < 20, 0, 0, 0, 0, k >= 8 && k < 20));
      if (k == 12) bus.sw_left = 1'b0;
    end
  endtask

  // Both turns from IDLE; release after edge rel. Recovery is the first step
  // edge at or after the fourth FAULT step that sees the conflict cleared.
  task automatic test_fault(input int rel);
    int e;
    do_reset();
    bus.sw_left  = 1'b1;
    bus.sw_right = 1'b1;
    e = 24;
    while (e <= rel + 4) e += 4;
    for (int k = 1; k <= e + 8; k++) begin
      cyc(rel > 8 ? "fault_sat" : "fault",
          pk(k % 4 == 3, 0, 0, 0, k >= e && k < e + 4, k >= 8 && k < e, 0));
      if (k == rel) begin
        bus.sw_left  = 1'b0;
        bus.sw_right = 1'b0;
      end
    end
  endtask

  task automatic test_lamp_error();
    do_reset();
    bus.sw_right = 1'b1;
    bus.sw_brake = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      cyc("lamp_err", pk(k % 4 == 3, 0, k >= 8 && k < 12, k >= 4 && k < 12,
                         0, k >= 12, k >= 8 && k < 12));
      if (k == 9) bus.lamp_error = 1'b1;
    end
    restart = 1'b1;
    cyc("mid_reset", pk(0, 0, 0, 0, 1, 0, 0));
    restart = 1'b0;
    clear_inputs();
    for (int j = 1; j <= 8; j++)
      cyc("post_reset", pk(j % 4 == 3, 0, 0, 0, 0, 0, 0));
  endtask

  initial begin
    restart = 1'b1;
    clear_inputs();
    test_reset();
    test_left_hold();
    test_glitch();
    test_min_hold();
    test_fault(8);
    test_fault(30);
    test_lamp_error();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
